// File: rtl/alu_pkg.sv
// Shared types and constants for the execute stage and its multiply/divide sequencer.
package alu_pkg;

  localparam int MDU_ITERS = 16;
  localparam int MDU_CNT_W = $clog2(MDU_ITERS);

  typedef enum logic [2:0] {
    ADD,
    SUB,
    AND,
    OR,
    SLL,
    SRL,
    MUL,
    DIV
  } control_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_e;

  // Two's-complement negate when n is set; also yields the magnitude of a signed value.
  function automatic logic [15:0] cond_neg16(input logic n, input logic [15:0] v);
    return n ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exec_stage_b_if.sv
// Stage-A-to-EX/MEM bundle for exec_stage_b: operands and control in, registered results out,
// plus the global freeze and the upstream hold request.
interface exec_stage_b_if;
  import alu_pkg::*;

  logic        halt_sys;
  logic [1:0]  in_memc;
  logic        in_reg_wr;
  logic [15:0] in_alu_a;
  logic [15:0] in_alu_b;
  logic [15:0] in_R1_data;
  logic        in_R0_en;
  control_e    in_alu_ctrl;
  logic [7:0]  in_instr;

  logic        stall_out;
  logic [1:0]  out_memc;
  logic        out_reg_wr;
  logic [7:0]  out_instr;
  logic [15:0] out_result;
  logic [15:0] out_R0_data;
  logic        out_R0_en;
  logic [15:0] out_store_data;

  modport slave (
    input  halt_sys, in_memc, in_reg_wr, in_alu_a, in_alu_b, in_R1_data, in_R0_en,
           in_alu_ctrl, in_instr,
    output stall_out, out_memc, out_reg_wr, out_instr, out_result, out_R0_data,
           out_R0_en, out_store_data
  );

  modport master (
    output halt_sys, in_memc, in_reg_wr, in_alu_a, in_alu_b, in_R1_data, in_R0_en,
           in_alu_ctrl, in_instr,
    input  stall_out, out_memc, out_reg_wr, out_instr, out_result, out_R0_data,
           out_R0_en, out_store_data
  );

endinterface

// File: rtl/exec_stage_b_mdu_seq.sv
// Iterative signed multiply (and, with MDU_DIV_EN defined, restoring divide) sequencer.
// Works on operand magnitudes for MDU_ITERS iterations; the sign fix-up is applied in DONE.
module mdu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        start,
`ifdef MDU_DIV_EN
  input  logic        op_div,
`endif
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] hi,
  output logic [15:0] lo
);

  mdu_state_e           state;
  mdu_state_e           state_nxt;
  logic [MDU_CNT_W-1:0] cnt;
  logic [15:0]          acc_hi;
  logic [15:0]          acc_lo;
  logic [15:0]          mag_op;
  logic                 sign_a;
  logic                 sign_b;
  logic [15:0]          mag_a;
  logic [15:0]          mag_b;
  logic [16:0]          mul_sum;
  logic [15:0]          step_hi;
  logic [15:0]          step_lo;
  logic [31:0]          prod_fix;
`ifdef MDU_DIV_EN
  logic                 is_div;
  logic [16:0]          div_shift;
  logic [16:0]          div_diff;
`endif

  assign mag_a = cond_neg16(op_a[15], op_a);
  assign mag_b = cond_neg16(op_b[15], op_b);

  // State register; a freeze holds the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (!halt_sys) begin
      state <= state_nxt;
    end
  end

  // Next state: start from IDLE, run MDU_ITERS iterations in BUSY, spend one cycle in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == MDU_CNT_W'(MDU_ITERS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State decode presented to the execute stage.
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // One shift/accumulate step: multiply shifts the 32-bit {acc_hi,acc_lo} right while adding the
  // multiplicand into the top half; divide shifts left and restores when the trial subtract borrows.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_op} : 17'd0);
    step_hi = mul_sum[16:1];
    step_lo = {mul_sum[0], acc_lo[15:1]};
`ifdef MDU_DIV_EN
    div_shift = {acc_hi, acc_lo[15]};
    div_diff  = div_shift - {1'b0, mag_op};
    if (is_div) begin
      if (!div_diff[16]) begin
        step_hi = div_diff[15:0];
        step_lo = {acc_lo[14:0], 1'b1};
      end else begin
        step_hi = div_shift[15:0];
        step_lo = {acc_lo[14:0], 1'b0};
      end
    end
`endif
  end

  // Datapath registers: latch magnitudes and signs on start, iterate while BUSY, hold on freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_op <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (!halt_sys) begin
      if (state == IDLE && start) begin
        cnt    <= '0;
        acc_hi <= '0;
        sign_a <= op_a[15];
        sign_b <= op_b[15];
        acc_lo <= mag_b;
        mag_op <= mag_a;
`ifdef MDU_DIV_EN
        is_div <= op_div;
        if (op_div) begin
          acc_lo <= mag_a;
          mag_op <= mag_b;
        end
`endif
      end else if (state == BUSY) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end
    end
  end

  // Sign fix-up: product negated when the operand signs differ; quotient takes sign(a)^sign(b),
  // remainder takes sign(a).
  always_comb begin
    prod_fix = cond_neg32(sign_a ^ sign_b, {acc_hi, acc_lo});
    hi       = prod_fix[31:16];
    lo       = prod_fix[15:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      lo = cond_neg16(sign_a ^ sign_b, acc_lo);
      hi = cond_neg16(sign_a, acc_hi);
    end
`endif
  end

endmodule

// File: rtl/exec_stage_b.sv
// Execute stage B: single-cycle ALU, multi-cycle signed MUL/DIV via mdu_seq, upstream stall,
// and the EX/MEM output register. Define MDU_DIV_EN to build the divider; otherwise DIV is a NOP.
module exec_stage_b
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  exec_stage_b_if.slave  bus
);

  logic        mdu_op;
  logic        hold_req;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [15:0] alu_res;
  logic [15:0] alu_r0;
  logic        alu_r0_en;
  logic        alu_reg_wr;

  // A multi-cycle op is MUL, or DIV with a nonzero divisor when the divider is built.
  always_comb begin
    mdu_op = (bus.in_alu_ctrl == MUL);
`ifdef MDU_DIV_EN
    if (bus.in_alu_ctrl == DIV && bus.in_alu_b != 16'h0000) mdu_op = 1'b1;
`endif
  end

  assign hold_req      = (!busy && !done && mdu_op) || busy;
  assign bus.stall_out = hold_req & ~rst;

  mdu_seq u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .halt_sys (bus.halt_sys),
    .start    (mdu_op),
`ifdef MDU_DIV_EN
    .op_div   (bus.in_alu_ctrl == DIV),
`endif
    .op_a     (bus.in_alu_a),
    .op_b     (bus.in_alu_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Single-cycle ALU results; divide-by-zero is resolved here without involving the sequencer.
  always_comb begin
    alu_res    = '0;
    alu_r0     = '0;
    alu_r0_en  = bus.in_R0_en;
    alu_reg_wr = bus.in_reg_wr;
    case (bus.in_alu_ctrl)
      ADD: alu_res = bus.in_alu_a + bus.in_alu_b;
      SUB: alu_res = bus.in_alu_a - bus.in_alu_b;
      AND: alu_res = bus.in_alu_a & bus.in_alu_b;
      OR:  alu_res = bus.in_alu_a | bus.in_alu_b;
      SLL: alu_res = bus.in_alu_a << bus.in_alu_b[3:0];
      SRL: alu_res = bus.in_alu_a >> bus.in_alu_b[3:0];
      DIV: begin
`ifdef MDU_DIV_EN
        alu_res   = 16'hFFFF;
        alu_r0    = bus.in_alu_a;
        alu_r0_en = 1'b1;
`else
        alu_r0_en  = 1'b0;
        alu_reg_wr = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // EX/MEM register: bubble while holding upstream, sequencer result in DONE, ALU result otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_memc       <= '0;
      bus.out_reg_wr     <= 1'b0;
      bus.out_instr      <= '0;
      bus.out_result     <= '0;
      bus.out_R0_data    <= '0;
      bus.out_R0_en      <= 1'b0;
      bus.out_store_data <= '0;
    end else if (!bus.halt_sys) begin
      if (hold_req) begin
        bus.out_memc       <= '0;
        bus.out_reg_wr     <= 1'b0;
        bus.out_instr      <= '0;
        bus.out_result     <= '0;
        bus.out_R0_data    <= '0;
        bus.out_R0_en      <= 1'b0;
        bus.out_store_data <= '0;
      end else if (done) begin
        bus.out_memc       <= bus.in_memc;
        bus.out_reg_wr     <= bus.in_reg_wr;
        bus.out_instr      <= bus.in_instr;
        bus.out_result     <= lo;
        bus.out_R0_data    <= hi;
        bus.out_R0_en      <= 1'b1;
        bus.out_store_data <= bus.in_R1_data;
      end else begin
        bus.out_memc       <= bus.in_memc;
        bus.out_reg_wr     <= alu_reg_wr;
        bus.out_instr      <= bus.in_instr;
        bus.out_result     <= alu_res;
        bus.out_R0_data    <= alu_r0;
        bus.out_R0_en      <= alu_r0_en;
        bus.out_store_data <= bus.in_R1_data;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_b.sv
// Scoreboard bench for exec_stage_b: the stimulus process acts as stage A (holding while
// stall_out is high) and queues expected EX/MEM contents; a monitor pops and compares them.
module tb_exec_stage_b;
  import alu_pkg::*;

  logic clk;
  logic rst;

  exec_stage_b_if bus ();

  exec_stage_b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] result;
    logic [15:0] r0_data;
    logic [15:0] store_data;
    logic [7:0]  instr;
    logic [1:0]  memc;
    logic        r0_en;
    logic        reg_wr;
    int          due_cycle;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   div_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack_out();
    return {4'h0, bus.out_result, bus.out_R0_data, bus.out_store_data, bus.out_instr,
            bus.out_memc, bus.out_R0_en, bus.out_reg_wr};
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {4'h0, e.result, e.r0_data, e.store_data, e.instr, e.memc, e.r0_en, e.reg_wr};
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic rules: signed product, truncating signed division.
  function automatic void model_op(input control_e ctrl, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] r1, input logic reg_wr, input logic r0_en,
                                   input logic [1:0] memc, input logic [7:0] instr,
                                   output exp_t e, output bit multi);
    int sa, sb, prod, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.result = '0; e.r0_data = '0; e.store_data = r1; e.instr = instr; e.memc = memc;
    e.r0_en = r0_en; e.reg_wr = reg_wr; e.due_cycle = 0;
    multi = 1'b0;
    case (ctrl)
      ADD: e.result = 16'(a + b);
      SUB: e.result = 16'(a - b);
      AND: e.result = a & b;
      OR:  e.result = a | b;
      SLL: e.result = a << b[3:0];
      SRL: e.result = a >> b[3:0];
      MUL: begin
        prod = sa * sb;
        e.result = prod[15:0]; e.r0_data = prod[31:16]; e.r0_en = 1'b1; multi = 1'b1;
      end
      DIV: begin
        if (!div_en) begin
          e.reg_wr = 1'b0; e.r0_en = 1'b0;
        end else if (b == 16'h0000) begin
          e.result = 16'hFFFF; e.r0_data = a; e.r0_en = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          e.result = q[15:0]; e.r0_data = r[15:0]; e.r0_en = 1'b1; multi = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic drive_idle();
    bus.in_alu_ctrl = ADD;
    bus.in_alu_a = '0; bus.in_alu_b = '0; bus.in_R1_data = '0;
    bus.in_reg_wr = 1'b0; bus.in_R0_en = 1'b0; bus.in_memc = '0; bus.in_instr = '0;
  endtask

  // Present one op as stage A would, hold it while stalled, and check the stall window length.
  // halt_start < 0 picks a position automatically (a BUSY cycle for multi-cycle ops).
  task automatic apply_stimulus(input control_e ctrl, input logic [15:0] a, input logic [15:0] b,
                                input logic reg_wr, input logic r0_en, input logic [1:0] memc,
                                input logic [15:0] r1, input logic [7:0] instr,
                                input int halt_start, input int halt_len);
    exp_t e;
    bit   multi, accepted;
    int   rel, stall_cnt, exp_stall, hs;
    logic st, hl;
    @(negedge clk);
    bus.in_alu_ctrl = ctrl; bus.in_alu_a = a; bus.in_alu_b = b; bus.in_reg_wr = reg_wr;
    bus.in_R0_en = r0_en; bus.in_memc = memc; bus.in_R1_data = r1; bus.in_instr = instr;
    model_op(ctrl, a, b, r1, reg_wr, r0_en, memc, instr, e, multi);
    hs = halt_start;
    if (hs < 0) hs = multi ? int'($urandom_range(1, 12)) : 0;
    e.due_cycle = cyc + (multi ? 18 : 1) + halt_len;
    exp_stall   = multi ? 17 + halt_len : 0;
    sb_q.push_back(e);
    rel = 0; stall_cnt = 0; accepted = 1'b0;
    while (!accepted && rel < 200) begin
      hl = (rel >= hs) && (rel < hs + halt_len);
      bus.halt_sys = hl;
      #1;
      st = bus.stall_out;
      if (st) stall_cnt++;
      @(posedge clk);
      if (!st && !hl) accepted = 1'b1;
      else begin
        @(negedge clk);
        rel++;
      end
    end
    bus.halt_sys = 1'b0;
    if (!accepted) check_output("handshake_timeout", 64'(rel), 64'(exp_stall));
    else check_output("stall_window", 64'(stall_cnt), 64'(exp_stall));
  endtask

  // Monitor: every edge that loads the output register yields either a result (nonzero
  // instr tag) matched against the queue head with its due cycle, or an all-zero bubble.
  initial begin : monitor
    exp_t e;
    logic h_at, r_at;
    forever begin
      @(posedge clk);
      h_at = bus.halt_sys;
      r_at = rst;
      #1;
      if (!(h_at || r_at || rst)) begin
        if (bus.out_instr != 8'h00) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_output", pack_out(), 64'h0);
          end else begin
            e = sb_q.pop_front();
            check_output("result_fields", pack_out(), pack_exp(e));
            check_output("result_cycle", 64'(cyc), 64'(e.due_cycle));
          end
        end else begin
          check_output("bubble", pack_out(), 64'h0);
        end
      end
    end
  end

  // Reset in the middle of a multiply: outputs and stall drop at once, the op is abandoned.
  task automatic reset_mid_op();
    exp_t e;
    bit   multi;
    @(negedge clk);
    bus.in_alu_ctrl = MUL; bus.in_alu_a = 16'h0100; bus.in_alu_b = 16'h0100;
    bus.in_reg_wr = 1'b1; bus.in_R0_en = 1'b0; bus.in_memc = 2'b01;
    bus.in_R1_data = 16'hBEEF; bus.in_instr = 8'h5A;
    repeat (9) @(negedge clk);
    #1;
    check_output("stall_before_reset", 64'(bus.stall_out), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    check_output("stall_in_reset", 64'(bus.stall_out), 64'h0);
    check_output("outputs_in_reset", pack_out(), 64'h0);
    bus.in_alu_ctrl = ADD; bus.in_alu_a = 16'd2; bus.in_alu_b = 16'd3;
    bus.in_reg_wr = 1'b1; bus.in_R0_en = 1'b0; bus.in_memc = 2'b00;
    bus.in_R1_data = 16'h0000; bus.in_instr = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    model_op(ADD, 16'd2, 16'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 8'h33, e, multi);
    e.due_cycle = cyc + 1;
    sb_q.push_back(e);
  endtask

  initial begin : stimulus
    control_e ctrl;
    logic [15:0] a, b;
    int wait_cnt, hlen;
`ifdef MDU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    rst = 1'b0;
    bus.halt_sys = 1'b0;
    drive_idle();
    bus.in_alu_ctrl = MUL; bus.in_alu_a = 16'd3; bus.in_alu_b = 16'd3;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_stall", 64'(bus.stall_out), 64'h0);
    check_output("reset_outputs", pack_out(), 64'h0);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 2'b10, 16'h1111, 8'h01, 0, 0);
    apply_stimulus(MUL, 16'h0100, 16'h0100, 1'b1, 1'b0, 2'b00, 16'h2222, 8'h02, 0, 0);
    apply_stimulus(MUL, 16'hFFFD, 16'h0005, 1'b0, 1'b0, 2'b01, 16'h3333, 8'h03, 0, 0);
    apply_stimulus(DIV, 16'd100,  16'd7,    1'b1, 1'b0, 2'b00, 16'h4444, 8'h04, 0, 0);
    apply_stimulus(DIV, 16'hFFF9, 16'h0002, 1'b1, 1'b1, 2'b11, 16'h5555, 8'h05, 0, 0);
    apply_stimulus(DIV, 16'h1234, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h6666, 8'h06, 0, 0);
    apply_stimulus(MUL, 16'h1234, 16'hFF00, 1'b1, 1'b0, 2'b00, 16'h7777, 8'h07, 5, 3);
    apply_stimulus(SUB, 16'h0000, 16'h0001, 1'b1, 1'b1, 2'b00, 16'h8888, 8'h08, 0, 0);
    apply_stimulus(SLL, 16'h0001, 16'h00FF, 1'b1, 1'b0, 2'b00, 16'h9999, 8'h09, 0, 0);
    apply_stimulus(SRL, 16'h8000, 16'h000F, 1'b1, 1'b0, 2'b00, 16'hAAAA, 8'h0A, 0, 2);
    apply_stimulus(MUL, 16'h8000, 16'h8000, 1'b1, 1'b0, 2'b00, 16'hBBBB, 8'h0B, 0, 0);
    apply_stimulus(DIV, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 2'b00, 16'hCCCC, 8'h0C, 0, 0);
    reset_mid_op();
    apply_stimulus(MUL, 16'h0007, 16'hFFFF, 1'b1, 1'b0, 2'b00, 16'hDDDD, 8'h0D, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ctrl = control_e'(3'($urandom_range(0, 7)));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 5) == 0) b = 16'h0000;
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      hlen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      apply_stimulus(ctrl, a, b, 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
                     8'($urandom_range(1, 255)), -1, hlen);
    end

    @(negedge clk);
    drive_idle();
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_output("drain_queue", 64'(sb_q.size()), 64'h0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exec_stage_b.md
# exec_stage_b

Execute stage of the 16-bit pipeline, directly downstream of the ID/EX register (stage A). It consumes the stage-A register outputs and computes single-cycle ALU results. It also runs multi-cycle signed MUL/DIV on an iterative sequencer and registers everything into the EX/MEM boundary. While a multi-cycle operation is in progress it back-pressures the front of the pipe through `stall_out`, which drives the `stall` input of stage A and everything upstream of it.

## Interface
Parameters: none; the iteration count `MDU_ITERS` (16) lives in `alu_pkg`.

Ports:
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `halt_sys` in 1 — global freeze; no state or output changes while high.
- `in_memc` in 2 — memory control from stage A.
- `in_reg_wr` in 1 — register-write enable from stage A.
- `in_alu_a`, `in_alu_b` in 16 each — operands.
- `in_R1_data` in 16 — store data.
- `in_R0_en` in 1 — R0 write request.
- `in_alu_ctrl` in `control_e` — operation select.
- `in_instr` in 8 — opcode and destination register.
- `stall_out` out 1 — combinational hold request to upstream stages.
- `out_memc` out 2, `out_reg_wr` out 1, `out_instr` out 8 — registered pass-through.
- `out_result` out 16 — ALU result, product low half, or quotient.
- `out_R0_data` out 16 — product high half or remainder.
- `out_R0_en` out 1 — R0 write enable.
- `out_store_data` out 16 — registered copy of `in_R1_data`.

## Operation
Single-cycle ops:
- ADD, SUB, AND, OR: 16-bit, wrap-around, no flags.
- SLL, SRL: shift amount is `in_alu_b[3:0]`; zero fill.
- `out_R0_data` is 0 and `out_R0_en` is `in_R0_en`.

MUL:
- Signed 16×16→32.
- Sequencer operates on operand magnitudes; sign fix-up happens in DONE.
- `out_result` = product[15:0], `out_R0_data` = product[31:16], `out_R0_en` forced 1.

DIV:
- Signed restoring division on magnitudes.
- Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- `out_result` = quotient, `out_R0_data` = remainder, `out_R0_en` forced 1.
- Divisor zero is resolved in one cycle with no stall: quotient 16'hFFFF, remainder = dividend.

Sequencer FSM (`IDLE`, `BUSY`, `DONE`):
- IDLE → BUSY: when `in_alu_ctrl` is MUL, or DIV with a nonzero divisor. Operands and signs are latched and the 4-bit counter is set to 0.
- BUSY: one iteration per edge. After the edge where the counter is 15, go to DONE.
- DONE → IDLE: the result is written to the outputs on this edge.
- `stall_out` = (IDLE and a multi-cycle op is present) or BUSY. It is low in DONE, so stage A advances on the same edge that registers the result.

Outputs while the sequencer is busy:
- On every edge while `stall_out` is high, the output register loads a bubble: `out_reg_wr`=0, `out_memc`=0, `out_R0_en`=0, other fields 0.
- In DONE, the control fields loaded are the held stage-A values.

`halt_sys`:
- Counter, FSM and all outputs hold.
- `stall_out` keeps reflecting the current state.

Reset (including mid-operation):
- All outputs 0, `stall_out` 0, FSM to IDLE, counter 0.
- Any partial operation is abandoned.

## Timing
- Single-cycle op presented in cycle N: result valid at outputs in cycle N+1.
- MUL/DIV presented in cycle 0:
  - `stall_out` is high in cycles 0–16 (17 cycles).
  - DONE occurs in cycle 17.
  - Result is valid in cycle 18, giving a latency of 18 cycles.
- Each `halt_sys` cycle extends these figures by exactly one cycle.
- `stall_out` depends only on the FSM state and `in_alu_ctrl`/`in_alu_b`; it has no path from `halt_sys`.

## Configuration
- `MDU_DIV_EN` defined: divider datapath is built as described above.
- `MDU_DIV_EN` undefined:
  - DIV executes as a one-cycle NOP: `out_reg_wr`=0, `out_R0_en`=0, `out_result`=0, no stall.
  - The sequencer is multiply-only.

## Structure
- `alu_pkg` gains:
  - `mdu_state_e` {IDLE, BUSY, DONE};
  - `MDU_ITERS` = 16;
  - MUL and DIV members of `control_e`, alongside ADD, SUB, AND, OR, SLL, SRL.
- One sub-module, `mdu_seq`: contains the FSM, counter, shift/accumulate datapath and sign fix-up. It exports `busy`, `done`, `hi` and `lo`.
- `exec_stage_b` contains the combinational ALU, the stall logic and the output register.

## Test plan
- ADD 16'h7FFF + 16'h0001 with `in_reg_wr`=1 → next cycle `out_result`=16'h8000, `out_reg_wr`=1; `stall_out` never asserts.
- MUL 16'h0100 × 16'h0100:
  - `stall_out` high for exactly 17 cycles, with bubbles (`out_reg_wr`=0) during that window;
  - cycle 18: `out_result`=16'h0000, `out_R0_data`=16'h0001, `out_R0_en`=1.
- MUL 16'hFFFD × 16'h0005 → `out_result`=16'hFFF1, `out_R0_data`=16'hFFFF.
- DIV cases:
  - 100/7 → quotient 16'h000E, remainder 16'h0002;
  - −7/2 → quotient 16'hFFFD, remainder 16'hFFFF;
  - 16'h1234/0 → quotient 16'hFFFF, remainder 16'h1234, with no stall and a 1-cycle result.
- `halt_sys` high for 3 cycles starting in BUSY cycle 5 → `stall_out` window lasts 20 cycles; product is unchanged.
- `rst` pulsed in BUSY cycle 8 → outputs and `stall_out` go 0 immediately. The following ADD 2+3 gives 16'h0005 one cycle after reset is released.
